// File: rtl/relu_act_sequencer.sv
// Activation stage: ReLU + shift/saturate quantization of one LANES-wide partial-sum
// vector per handshake, streamed out as OUT_LANES-wide beats with an incrementing address.
module relu_act_sequencer #(
    parameter int IN_PRECISION  = 18,
    parameter int OUT_PRECISION = 4,
    parameter int LANES         = 64,
    parameter int OUT_LANES     = 16,
    parameter int ADDR_W        = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic [4:0]                         cfg_shift,
    input  logic                               cfg_sat,
    input  logic [ADDR_W-1:0]                  cfg_num_vec,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [IN_PRECISION*LANES-1:0]      in_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [OUT_PRECISION*OUT_LANES-1:0] out_data,
    output logic [ADDR_W-1:0]                  out_addr,
    output logic                               busy,
    output logic                               done
);

    localparam int BEATS   = LANES / OUT_LANES;
    localparam int BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int VEC_W   = OUT_PRECISION * LANES;
    localparam int BEAT_DW = OUT_PRECISION * OUT_LANES;
    localparam int MAG_W   = IN_PRECISION - 1;

    localparam logic [BEAT_W-1:0] LAST_BEAT   = BEAT_W'(BEATS - 1);
    localparam logic [4:0]        SHIFT_LIMIT = 5'(IN_PRECISION - 1);
    localparam logic [MAG_W-1:0]  Q_MAX_EXT   = MAG_W'((1 << OUT_PRECISION) - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_EMIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              state_q,   state_d;
    logic [4:0]          shift_q,   shift_d;
    logic                sat_q,     sat_d;
    logic [ADDR_W-1:0]   num_vec_q, num_vec_d;
    logic [ADDR_W-1:0]   vec_cnt_q, vec_cnt_d;
    logic [BEAT_W-1:0]   beat_q,    beat_d;
    logic [ADDR_W-1:0]   addr_q,    addr_d;
    logic [VEC_W-1:0]    vec_q,     vec_d;
    logic [VEC_W-1:0]    quant_all_s;
    logic [VEC_W-1:0]    vec_shift_s;

    // Negative lanes clamp to zero; shifts that consume every magnitude bit give zero.
    function automatic logic [OUT_PRECISION-1:0] quantize(
        input logic [IN_PRECISION-1:0] x,
        input logic [4:0]              shift,
        input logic                    sat
    );
        logic [MAG_W-1:0]         mag_v;
        logic [OUT_PRECISION-1:0] q_v;
        mag_v = {MAG_W{1'b0}};
        q_v   = {OUT_PRECISION{1'b0}};
        if (x[IN_PRECISION-1]) begin
            q_v = {OUT_PRECISION{1'b0}};
        end else begin
            if (shift >= SHIFT_LIMIT) begin
                mag_v = {MAG_W{1'b0}};
            end else begin
                mag_v = x[MAG_W-1:0] >> shift;
            end
            if (sat && (mag_v > Q_MAX_EXT)) begin
                q_v = {OUT_PRECISION{1'b1}};
            end else begin
                q_v = mag_v[OUT_PRECISION-1:0];
            end
        end
        return q_v;
    endfunction

    // Quantize every lane of the incoming vector with the latched job config.
    always_comb begin
        quant_all_s = {VEC_W{1'b0}};
        for (int i = 0; i < LANES; i++) begin
            quant_all_s[i*OUT_PRECISION +: OUT_PRECISION] =
                quantize(in_data[i*IN_PRECISION +: IN_PRECISION], shift_q, sat_q);
        end
    end

    // Next-state and datapath update for the IDLE/LOAD/EMIT/DONE sequencer.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        sat_d     = sat_q;
        num_vec_d = num_vec_q;
        vec_cnt_d = vec_cnt_q;
        beat_d    = beat_q;
        addr_d    = addr_q;
        vec_d     = vec_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    shift_d   = cfg_shift;
                    sat_d     = cfg_sat;
                    num_vec_d = cfg_num_vec;
                    vec_cnt_d = {ADDR_W{1'b0}};
                    beat_d    = {BEAT_W{1'b0}};
                    addr_d    = {ADDR_W{1'b0}};
                    if (cfg_num_vec == {ADDR_W{1'b0}}) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_LOAD;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                if (in_valid) begin
                    vec_d   = quant_all_s;
                    beat_d  = {BEAT_W{1'b0}};
                    state_d = S_EMIT;
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_EMIT: begin
                if (out_ready) begin
                    beat_d = beat_q + BEAT_W'(1);
                    addr_d = addr_q + ADDR_W'(1);
                    if (beat_q == LAST_BEAT) begin
                        vec_cnt_d = vec_cnt_q + ADDR_W'(1);
                        if (vec_cnt_d == num_vec_q) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_LOAD;
                        end
                    end else begin
                        state_d = S_EMIT;
                    end
                end else begin
                    state_d = S_EMIT;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, config and datapath registers; reset aborts any job in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            shift_q   <= 5'd0;
            sat_q     <= 1'b0;
            num_vec_q <= {ADDR_W{1'b0}};
            vec_cnt_q <= {ADDR_W{1'b0}};
            beat_q    <= {BEAT_W{1'b0}};
            addr_q    <= {ADDR_W{1'b0}};
            vec_q     <= {VEC_W{1'b0}};
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            sat_q     <= sat_d;
            num_vec_q <= num_vec_d;
            vec_cnt_q <= vec_cnt_d;
            beat_q    <= beat_d;
            addr_q    <= addr_d;
            vec_q     <= vec_d;
        end
    end

    // Beat select: lane block beat_q of the held vector, lowest lane in the lowest bits.
    assign vec_shift_s = vec_q >> (32'(beat_q) * BEAT_DW);
    assign out_data    = vec_shift_s[BEAT_DW-1:0];
    assign out_addr    = addr_q;
    assign in_ready    = (state_q == S_LOAD);
    assign out_valid   = (state_q == S_EMIT);
    assign busy        = (state_q == S_LOAD) || (state_q == S_EMIT);
    assign done        = (state_q == S_DONE);

endmodule

// File: tb/tb_relu_act_sequencer.sv
// Directed bench for relu_act_sequencer: expected beats are queued when a vector is
// driven and popped by a negedge monitor when the DUT completes a beat handshake.
module tb_relu_act_sequencer;

    localparam int INP = 18;
    localparam int OUTP = 4;
    localparam int LANES = 64;
    localparam int OLANES = 16;
    localparam int AW = 8;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   start = 1'b0;
    logic [4:0]             cfg_shift = 5'd0;
    logic                   cfg_sat = 1'b0;
    logic [AW-1:0]          cfg_num_vec = 8'd0;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic [INP*LANES-1:0]   in_data = '0;
    logic                   out_valid;
    logic                   out_ready = 1'b1;
    logic [OUTP*OLANES-1:0] out_data;
    logic [AW-1:0]          out_addr;
    logic                   busy;
    logic                   done;

    relu_act_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .cfg_shift(cfg_shift), .cfg_sat(cfg_sat),
        .cfg_num_vec(cfg_num_vec), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int          beats_seen = 0;
    int          done_seen = 0;
    int          cyc_n = 0;
    bit          bp_en = 1'b0;
    bit [3:0]    bp_pat = 4'b1001;
    logic [71:0] exp_q[$];
    logic [AW-1:0] model_addr = 8'd0;
    int          lanes_m[LANES];

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int qm(input int x, input int sh, input bit sat);
        int v;
        if (x < 0) return 0;
        v = (sh >= INP - 1) ? 0 : (x >> sh);
        return sat ? ((v > 15) ? 15 : v) : (v % 16);
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
        cyc_n++;
        if (bp_en) out_ready = bp_pat[cyc_n % 4];
    endtask

    task automatic do_start(input int sh, input bit sat, input int nv);
        cfg_shift = 5'(sh);
        cfg_sat = sat;
        cfg_num_vec = AW'(nv);
        start = 1'b1;
        cycle();
        start = 1'b0;
        model_addr = 8'd0;
    endtask

    task automatic send_vec(input int sh, input bit sat);
        logic [63:0] d;
        int n;
        for (int i = 0; i < LANES; i++) in_data[i*INP +: INP] = INP'(lanes_m[i]);
        for (int b = 0; b < 4; b++) begin
            d = '0;
            for (int j = 0; j < OLANES; j++) d[j*OUTP +: OUTP] = 4'(qm(lanes_m[b*OLANES+j], sh, sat));
            exp_q.push_back({model_addr, d});
            model_addr = model_addr + 8'd1;
        end
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 60) begin
            cycle();
            n++;
        end
        check("in_ready_wait", {79'd0, in_ready}, 80'd1);
        cycle();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!done && cycles < 400) begin
            cycle();
            cycles++;
        end
        check("done_seen", {79'd0, done}, 80'd1);
        check("sb_empty", 80'(exp_q.size()), 80'd0);
    endtask

    task automatic rand_lanes();
        for (int i = 0; i < LANES; i++) lanes_m[i] = int'($urandom_range(0, 262143)) - 131072;
    endtask

    // Monitor: scoreboard pops, stall stability, in_ready/done exclusivity during EMIT.
    initial begin : monitor
        bit          stall = 1'b0;
        logic [71:0] prev_word = '0;
        logic [71:0] exp_word;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (out_valid) begin
                    check("in_ready_in_emit", {79'd0, in_ready}, 80'd0);
                    check("done_with_valid", {79'd0, done}, 80'd0);
                    if (stall) check("stall_stable", {8'd0, out_addr, out_data}, {8'd0, prev_word});
                    if (out_ready) begin
                        check("beat_expected", {79'd0, exp_q.size() > 0}, 80'd1);
                        if (exp_q.size() > 0) begin
                            exp_word = exp_q.pop_front();
                            check("beat_addr_data", {8'd0, out_addr, out_data}, {8'd0, exp_word});
                        end
                        beats_seen++;
                    end
                    stall = !out_ready;
                    prev_word = {out_addr, out_data};
                end else begin
                    stall = 1'b0;
                end
                if (done) done_seen++;
            end else begin
                stall = 1'b0;
            end
        end
    end

    initial begin
        int c;
        int b0;
        int d0;

        // Reset state
        cycle();
        cycle();
        rst = 1'b0;
        check("rst_in_ready", {79'd0, in_ready}, 80'd0);
        check("rst_out_valid", {79'd0, out_valid}, 80'd0);
        check("rst_out_data", {16'd0, out_data}, 80'd0);
        check("rst_out_addr", {72'd0, out_addr}, 80'd0);
        check("rst_busy", {79'd0, busy}, 80'd0);
        check("rst_done", {79'd0, done}, 80'd0);

        // Basic ReLU
        for (int i = 0; i < LANES; i++) lanes_m[i] = (i % 2 == 0) ? i * 1000 : -5;
        b0 = beats_seen; d0 = done_seen;
        do_start(13, 1'b0, 1);
        check("start_to_accept", {79'd0, in_ready}, 80'd1);
        check("busy_load", {79'd0, busy}, 80'd1);
        send_vec(13, 1'b0);
        wait_done(c);
        check("done_latency", 80'(c), 80'd4);
        check("done_no_busy", {79'd0, busy}, 80'd0);
        cycle();
        check("done_one_cycle", {79'd0, done}, 80'd0);
        check("basic_beats", 80'(beats_seen - b0), 80'd4);
        check("basic_done_cnt", 80'(done_seen - d0), 80'd1);

        // Saturation / truncation
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < LANES; i++) lanes_m[i] = (k < 2) ? 131071 : 65536;
            do_start(4, (k % 2 == 0), 1);
            send_vec(4, (k % 2 == 0));
            wait_done(c);
            check("sat_done_latency", 80'(c), 80'd4);
            cycle();
        end

        // Backpressure, two vectors
        b0 = beats_seen;
        do_start(3, 1'b1, 2);
        bp_en = 1'b1;
        rand_lanes();
        send_vec(3, 1'b1);
        rand_lanes();
        send_vec(3, 1'b1);
        wait_done(c);
        bp_en = 1'b0;
        out_ready = 1'b1;
        check("bp_beats", 80'(beats_seen - b0), 80'd8);
        check("bp_last_addr", {72'd0, out_addr}, 80'd8);
        cycle();

        // Address wrap, 65 vectors
        b0 = beats_seen; d0 = done_seen;
        do_start(9, 1'b0, 65);
        for (int v = 0; v < 65; v++) begin
            rand_lanes();
            send_vec(9, 1'b0);
        end
        wait_done(c);
        cycle();
        check("wrap_beats", 80'(beats_seen - b0), 80'd260);
        check("wrap_done_cnt", 80'(done_seen - d0), 80'd1);
        check("wrap_addr_hold", {72'd0, out_addr}, 80'd4);

        // Zero-length job
        d0 = done_seen;
        do_start(0, 1'b0, 0);
        check("zero_done", {79'd0, done}, 80'd1);
        check("zero_in_ready", {79'd0, in_ready}, 80'd0);
        check("zero_out_valid", {79'd0, out_valid}, 80'd0);
        check("zero_busy", {79'd0, busy}, 80'd0);
        cycle();
        check("zero_done_drop", {79'd0, done}, 80'd0);

        // Reset during beat 2 of vector 1
        do_start(10, 1'b0, 3);
        rand_lanes();
        send_vec(10, 1'b0);
        rand_lanes();
        send_vec(10, 1'b0);
        cycle();
        cycle();
        check("mid_addr_beat2", {72'd0, out_addr}, 80'd6);
        d0 = done_seen;
        rst = 1'b1;
        cycle();
        check("mrst_out_valid", {79'd0, out_valid}, 80'd0);
        check("mrst_out_data", {16'd0, out_data}, 80'd0);
        check("mrst_out_addr", {72'd0, out_addr}, 80'd0);
        check("mrst_in_ready", {79'd0, in_ready}, 80'd0);
        check("mrst_busy", {79'd0, busy}, 80'd0);
        check("mrst_done", {79'd0, done}, 80'd0);
        rst = 1'b0;
        exp_q.delete();
        cycle();
        check("mrst_no_done", 80'(done_seen - d0), 80'd0);
        b0 = beats_seen;
        do_start(2, 1'b1, 1);
        rand_lanes();
        send_vec(2, 1'b1);
        wait_done(c);
        check("post_rst_beats", 80'(beats_seen - b0), 80'd4);
        cycle();

        // Config isolation: cfg changes and start pulse mid-job
        b0 = beats_seen; d0 = done_seen;
        do_start(5, 1'b1, 2);
        cfg_shift = 5'd17;
        cfg_sat = 1'b0;
        rand_lanes();
        send_vec(5, 1'b1);
        start = 1'b1;
        cycle();
        start = 1'b0;
        rand_lanes();
        send_vec(5, 1'b1);
        wait_done(c);
        cycle();
        check("iso_beats", 80'(beats_seen - b0), 80'd8);
        check("iso_done_cnt", 80'(done_seen - d0), 80'd1);
        check("iso_idle", {79'd0, busy}, 80'd0);
        cycle();
        check("iso_no_restart", {79'd0, in_ready}, 80'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/relu_act_sequencer.md
# relu_act_sequencer

Sequences the post-accumulation activation stage of the CIM processor. It accepts one 64-lane vector of signed partial sums per handshake and applies ReLU plus runtime-configurable shift/saturate quantization to OUT_PRECISION bits. It then streams the packed result to the activation buffer in OUT_LANES-wide beats with an auto-incrementing write address. It sits between the macro accumulator output and the activation SRAM write port, and counts a programmed number of vectors per job.

## Interface
- IN_PRECISION, 18, signed partial-sum width per lane
- OUT_PRECISION, 4, unsigned activation width per lane
- LANES, 64, lanes per input vector
- OUT_LANES, 16, lanes per output beat; LANES must be a multiple of OUT_LANES (BEATS = LANES/OUT_LANES = 4)
- ADDR_W, 8, activation buffer address and vector-count width

Ports:
- clk  input  1  clock; all logic is rising-edge
- rst  input  1  synchronous, active-high reset
- start  input  1  job start pulse; sampled only in IDLE
- cfg_shift  input  5  right-shift amount applied after ReLU; latched on start
- cfg_sat  input  1  1 = saturate to 2^OUT_PRECISION-1, 0 = truncate to low OUT_PRECISION bits; latched on start
- cfg_num_vec  input  ADDR_W  vectors in this job; latched on start
- in_valid  input  1  partial-sum vector valid
- in_ready  output  1  block accepts a vector
- in_data  input  IN_PRECISION*LANES  lane i at [IN_PRECISION*(i+1)-1 -: IN_PRECISION], two's complement
- out_valid  output  1  output beat valid
- out_ready  input  1  buffer accepts the beat
- out_data  output  OUT_PRECISION*OUT_LANES  beat lanes, lane j at [OUT_PRECISION*(j+1)-1 -: OUT_PRECISION]
- out_addr  output  ADDR_W  buffer write address of the current beat
- busy  output  1  high in LOAD and EMIT
- done  output  1  one-cycle pulse at job end

## Operation
- The FSM has four states: IDLE, LOAD, EMIT and DONE.
- **IDLE:** on start, latch cfg_*, clear vec_cnt, beat_cnt and out_addr.
  - If cfg_num_vec==0, go to DONE; otherwise go to LOAD.
  - start outside IDLE is ignored.
- **LOAD:** in_ready=1. On in_valid&&in_ready:
  - Register all LANES quantized values into a vector register.
  - Clear beat_cnt and go to EMIT.
- **Quantization per lane x:**
  - If x[IN_PRECISION-1]==1, the result is 0.
  - Otherwise v = x >> cfg_shift (logical, on the magnitude bits).
  - If cfg_shift >= IN_PRECISION-1, v = 0.
  - With cfg_sat=1, the result is min(v, 2^OUT_PRECISION-1); otherwise it is v[OUT_PRECISION-1:0].
  - cfg_shift=13 with cfg_sat=0 yields bits [16:13], i.e. the top four magnitude bits.
- **EMIT:** out_valid=1. out_data = register lanes beat_cnt*OUT_LANES .. +OUT_LANES-1, lowest lane in the lowest bits.
  - On out_valid&&out_ready: beat_cnt++, out_addr++.
  - out_addr wraps modulo 2^ADDR_W with no error.
  - On the handshake of beat BEATS-1: vec_cnt++. If the new vec_cnt==cfg_num_vec, go to DONE; otherwise go to LOAD.
  - out_data and out_addr hold stable while out_valid && !out_ready.
- **DONE:** done=1 for one cycle, then go to IDLE. out_addr is not cleared until the next start.
- in_ready is 0 in every state except LOAD. in_valid arriving in other states is left pending (no drop, no accept).
- A cfg_* change after start has no effect on the running job.

## Timing
- **Reset values:** state=IDLE; in_ready=0, out_valid=0, out_data=0, out_addr=0, busy=0, done=0; vector register and counters are 0.
- **Reset mid-job:** an asserted rst aborts immediately.
  - No done pulse is generated.
  - Any partially emitted vector is discarded.
- **Start to accept:** start at cycle t gives in_ready=1 from cycle t+1.
- **Input to output:** input handshake at cycle t gives out_valid=1 with beat 0 at t+1. Quantization is registered, one cycle of latency.
- **Throughput:** with out_ready held high, one vector every BEATS+1 = 5 cycles (1 LOAD + 4 EMIT).
- **Done timing:** the final beat handshake at cycle t gives done=1 at t+1 and state IDLE at t+2. busy is low from t+1.
- **Zero-length job:** cfg_num_vec==0 with start at t gives done at t+1.
  - in_ready is never raised.
  - out_valid is never raised.
- done and out_valid are never high in the same cycle.

## Test plan
- **Basic ReLU:** cfg_shift=13, cfg_sat=0, cfg_num_vec=1; lane i = i*1000 for even i, -5 for odd i. Required response:
  - Exactly 4 beats at out_addr 0..3.
  - Even lanes = (i*1000>>13)&15, e.g. lane 62 → 7; odd lanes = 0.
  - done one cycle after beat 3.
- **Saturation:** all lanes = 131071 (max positive), cfg_shift=4.
  - cfg_sat=1: every output lane = 15.
  - cfg_sat=0: every output lane = (131071>>4)&15 = 15.
  - Repeat with lanes = 0x10000 and cfg_shift=4: sat → 15, truncate → 0.
- **Backpressure:** cfg_num_vec=2, out_ready toggling 1-0-0-1 pattern. Required response:
  - out_data and out_addr stable during stalls.
  - 8 beats at addresses 0..7.
  - in_ready low throughout EMIT.
  - The second vector is accepted only after beat 3 of the first.
- **Address wrap:** ADDR_W=8, cfg_num_vec=65 (260 beats). Required response:
  - out_addr sequence 0..255, 0..3.
  - done once after the 260th beat.
- **Zero and reset:** cfg_num_vec=0 → done at t+1, no in_ready or out_valid. Then start a 3-vector job and assert rst during beat 2 of vector 1. Required response:
  - All outputs = 0 the next cycle, no done.
  - A new start runs cleanly from out_addr 0.
- **Config isolation:** change cfg_shift and cfg_sat mid-job and pulse start during EMIT. Required response:
  - Outputs still use the latched config.
  - Beat and vector counts are unaffected.
